// File: rtl/picobus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : picobus_pkg
//  Description : Shared types and constants for the PicoRV32 bus decoder:
//                FSM state encoding, default error read data, clog2 helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package picobus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERROR  = 2'd2,
    ST_DONE   = 2'd3
  } pb_state_e;

  localparam logic [31:0] PB_ERR_DATA = 32'hDEAD_BEEF;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int unsigned pb_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/picobus_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : picobus_decoder_if
//  Description : Bundles the PicoRV32 master side and the broadcast slave
//                side of the bus fabric. The "slave" modport is the decoder's
//                view (it serves the CPU); "master" is the surrounding SoC.
//  Revision    : 1.0 - initial release
// ============================================================================
interface picobus_decoder_if #(
  parameter int NSLAVES = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  // CPU-facing request/response
  logic                      m_valid;
  logic [ADDR_W-1:0]         m_addr;
  logic [DATA_W-1:0]         m_wdata;
  logic [DATA_W/8-1:0]       m_wstrb;
  logic [DATA_W-1:0]         m_rdata;
  logic                      m_ready;
  // Slave-facing broadcast request and per-slave responses
  logic [NSLAVES-1:0]        s_valid;
  logic [ADDR_W-1:0]         s_addr;
  logic [DATA_W-1:0]         s_wdata;
  logic [DATA_W/8-1:0]       s_wstrb;
  logic [NSLAVES*DATA_W-1:0] s_rdata;
  logic [NSLAVES-1:0]        s_ready;

  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb, s_rdata, s_ready,
    output m_rdata, m_ready, s_valid, s_addr, s_wdata, s_wstrb
  );

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb, s_rdata, s_ready,
    input  m_rdata, m_ready, s_valid, s_addr, s_wdata, s_wstrb
  );
endinterface
`default_nettype wire

// File: rtl/picobus_addr_match.sv
`default_nettype none
// ============================================================================
//  Module      : picobus_addr_match
//  Description : Combinational base/mask window compare across all slave
//                channels; lowest-index matching channel wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module picobus_addr_match
  import picobus_pkg::*;
#(
  parameter int                          NSLAVES    = 4,
  parameter int                          ADDR_W     = 32,
  parameter logic [NSLAVES*ADDR_W-1:0]   SLAVE_BASE = {NSLAVES*ADDR_W{1'b0}},
  parameter logic [NSLAVES*ADDR_W-1:0]   SLAVE_MASK = {NSLAVES{32'hFF00_0000}},
  localparam int                         SEL_W      = (NSLAVES > 1) ? int'(pb_clog2(NSLAVES)) : 1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [SEL_W-1:0]  sel
);

  logic [NSLAVES-1:0] match;

  for (genvar i = 0; i < NSLAVES; i++) begin : g_match
    assign match[i] = ((addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) ==
                       (SLAVE_BASE[i*ADDR_W +: ADDR_W] & SLAVE_MASK[i*ADDR_W +: ADDR_W]));
  end

  // Priority encode: scan high to low so the lowest matching index is left last.
  always_comb begin
    hit = |match;
    sel = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if (match[i]) sel = SEL_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/picobus_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : picobus_decoder
//  Description : PicoRV32 native-bus fabric: registered address decode onto
//                NSLAVES windows, registered response, ready timeout and a
//                sticky bus-error status with first-error address capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module picobus_decoder
  import picobus_pkg::*;
#(
  parameter int                        NSLAVES    = 4,
  parameter int                        ADDR_W     = 32,
  parameter int                        DATA_W     = 32,
  parameter logic [NSLAVES*ADDR_W-1:0] SLAVE_BASE = {NSLAVES*ADDR_W{1'b0}},
  parameter logic [NSLAVES*ADDR_W-1:0] SLAVE_MASK = {NSLAVES{32'hFF00_0000}},
  parameter int                        TIMEOUT    = 255,
  parameter logic [DATA_W-1:0]         ERR_DATA   = DATA_W'(PB_ERR_DATA)
) (
  input  logic              clk,
  input  logic              reset,
  picobus_decoder_if.slave  bus,
  input  logic              err_clear,
  output logic              err_flag,
  output logic [ADDR_W-1:0] err_addr
);

  localparam int SEL_W   = (NSLAVES > 1) ? int'(pb_clog2(NSLAVES)) : 1;
  localparam int CNT_RAW = int'(pb_clog2(TIMEOUT + 1));
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  pb_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [NSLAVES-1:0]    s_valid_q, s_valid_d;
  logic [ADDR_W-1:0]     s_addr_q, s_addr_d;
  logic [DATA_W-1:0]     s_wdata_q, s_wdata_d;
  logic [DATA_W/8-1:0]   s_wstrb_q, s_wstrb_d;
  logic [DATA_W-1:0]     m_rdata_q, m_rdata_d;
  logic                  m_ready_q, m_ready_d;
  logic                  err_flag_q, err_flag_d;
  logic [ADDR_W-1:0]     err_addr_q, err_addr_d;
  logic                  guard_q, guard_d;   // blocks a new request right after DONE

  logic                  match_hit;
  logic [SEL_W-1:0]      match_sel;

  picobus_addr_match #(
    .NSLAVES    (NSLAVES),
    .ADDR_W     (ADDR_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_match (
    .addr (bus.m_addr),
    .hit  (match_hit),
    .sel  (match_sel)
  );

  // Next-state, datapath and error-status logic for the transaction FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    s_valid_d  = s_valid_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    s_wstrb_d  = s_wstrb_q;
    m_rdata_d  = m_rdata_q;
    m_ready_d  = 1'b0;
    err_flag_d = err_flag_q;
    err_addr_d = err_addr_q;
    guard_d    = 1'b0;

    // A clear is overridden below by a simultaneous new error.
    if (err_clear) err_flag_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.m_valid && !guard_q) begin
          s_addr_d  = bus.m_addr;
          s_wdata_d = bus.m_wdata;
          s_wstrb_d = bus.m_wstrb;
          if (match_hit) begin
            state_d   = ST_ACTIVE;
            sel_d     = match_sel;
            s_valid_d = NSLAVES'(1) << match_sel;
            cnt_d     = '0;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_ACTIVE: begin
        // Ready is checked first so it wins over a coincident timeout.
        if (bus.s_ready[sel_q]) begin
          m_rdata_d = bus.s_rdata[int'(sel_q)*DATA_W +: DATA_W];
          s_valid_d = '0;
          m_ready_d = 1'b1;
          state_d   = ST_DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          s_valid_d = '0;
          state_d   = ST_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ERROR: begin
        m_rdata_d  = ERR_DATA;
        err_flag_d = 1'b1;
        if (!err_flag_q || err_clear) err_addr_d = s_addr_q;
        m_ready_d  = 1'b1;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        guard_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      s_valid_q  <= '0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_wstrb_q  <= '0;
      m_rdata_q  <= '0;
      m_ready_q  <= 1'b0;
      err_flag_q <= 1'b0;
      err_addr_q <= '0;
      guard_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      s_valid_q  <= s_valid_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      s_wstrb_q  <= s_wstrb_d;
      m_rdata_q  <= m_rdata_d;
      m_ready_q  <= m_ready_d;
      err_flag_q <= err_flag_d;
      err_addr_q <= err_addr_d;
      guard_q    <= guard_d;
    end
  end

  assign bus.s_valid = s_valid_q;
  assign bus.s_addr  = s_addr_q;
  assign bus.s_wdata = s_wdata_q;
  assign bus.s_wstrb = s_wstrb_q;
  assign bus.m_rdata = m_rdata_q;
  assign bus.m_ready = m_ready_q;
  assign err_flag    = err_flag_q;
  assign err_addr    = err_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_picobus_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_picobus_decoder
//  Description : Directed self-checking bench for picobus_decoder and its
//                address-match sub-module.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_picobus_decoder;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: four disjoint windows, TIMEOUT=8 ----------------
  picobus_decoder_if #(.NSLAVES(4), .ADDR_W(32), .DATA_W(32)) bus_a ();
  logic        err_clear_a;
  logic        err_flag_a;
  logic [31:0] err_addr_a;

  picobus_decoder #(
    .NSLAVES    (4),
    .ADDR_W     (32),
    .DATA_W     (32),
    .SLAVE_BASE ({32'h0300_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000}),
    .SLAVE_MASK ({4{32'hFF00_0000}}),
    .TIMEOUT    (8),
    .ERR_DATA   (32'hDEAD_BEEF)
  ) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_a),
    .err_clear (err_clear_a),
    .err_flag  (err_flag_a),
    .err_addr  (err_addr_a)
  );

  // ---------------- DUT B: slave0 matches everything, slave1 overlaps -----
  picobus_decoder_if #(.NSLAVES(2), .ADDR_W(32), .DATA_W(32)) bus_b ();
  logic        err_clear_b;
  logic        err_flag_b;
  logic [31:0] err_addr_b;

  picobus_decoder #(
    .NSLAVES    (2),
    .ADDR_W     (32),
    .DATA_W     (32),
    .SLAVE_BASE ({32'h0100_0000, 32'h0000_0000}),
    .SLAVE_MASK ({32'hFF00_0000, 32'h0000_0000}),
    .TIMEOUT    (255),
    .ERR_DATA   (32'hDEAD_BEEF)
  ) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_b),
    .err_clear (err_clear_b),
    .err_flag  (err_flag_b),
    .err_addr  (err_addr_b)
  );

  // ---------------- Stand-alone address matcher ---------------------------
  logic [31:0] um_addr;
  logic        um_hit;
  logic [1:0]  um_sel;

  picobus_addr_match #(
    .NSLAVES    (4),
    .ADDR_W     (32),
    .SLAVE_BASE ({32'h0300_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000}),
    .SLAVE_MASK ({32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFFFF_0000})
  ) u_match (
    .addr (um_addr),
    .hit  (um_hit),
    .sel  (um_sel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One master transaction on DUT A. The slave raises s_ready for the selected
  // channel once rdy_after cycles of s_valid have been seen. lat is the number
  // of sampling edges from the decode edge to m_ready (-1 if never seen).
  task automatic txn_a(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input int rdy_after,
                       output int lat, output int sv_hi, output logic [3:0] sv_seen,
                       output logic [31:0] rdata, output int n_rdy, output bit hold_ok);
    int stop;
    lat = -1; sv_hi = 0; sv_seen = '0; rdata = '0; n_rdy = 0; hold_ok = 1'b1; stop = 40;
    @(negedge clk);
    bus_a.m_valid = 1'b1;
    bus_a.m_addr  = addr;
    bus_a.m_wdata = wdata;
    bus_a.m_wstrb = wstrb;
    bus_a.s_ready = '0;
    for (int cyc = 1; cyc <= stop; cyc++) begin
      @(posedge clk); #1;
      if (bus_a.s_valid != '0) begin
        sv_hi++;
        sv_seen = sv_seen | bus_a.s_valid;
        if (bus_a.s_addr !== addr || bus_a.s_wdata !== wdata || bus_a.s_wstrb !== wstrb)
          hold_ok = 1'b0;
      end
      if (bus_a.m_ready) begin
        n_rdy++;
        if (lat < 0) begin
          lat   = cyc;
          rdata = bus_a.m_rdata;
          stop  = cyc + 4;
        end
        bus_a.m_valid = 1'b0;
      end
      bus_a.s_ready = (bus_a.s_valid != '0 && sv_hi > rdy_after) ? bus_a.s_valid : 4'b0000;
    end
    bus_a.s_ready = '0;
    bus_a.m_valid = 1'b0;
  endtask

  initial begin
    int          lat, sv_hi, n_rdy, cnt;
    logic [3:0]  sv_seen;
    logic [31:0] rdata;
    bit          hold_ok;

    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    err_clear_a = 1'b0;
    err_clear_b = 1'b0;
    bus_a.m_valid = 1'b0; bus_a.m_addr = '0; bus_a.m_wdata = '0; bus_a.m_wstrb = '0;
    bus_a.s_ready = '0;
    bus_a.s_rdata = {32'hCAFE_0003, 32'h0000_0002, 32'h1234_5678, 32'h0000_0000};
    bus_b.m_valid = 1'b0; bus_b.m_addr = '0; bus_b.m_wdata = '0; bus_b.m_wstrb = '0;
    bus_b.s_ready = '0;
    bus_b.s_rdata = {32'hBBBB_0001, 32'hAAAA_0000};
    um_addr = '0;

    // Address matcher alone (slave0 window narrowed to 0x0000_xxxx).
    um_addr = 32'h0200_0123; #1;
    chk("match_hit2", 32'(um_hit), 32'd1);
    chk("match_sel2", 32'(um_sel), 32'd2);
    um_addr = 32'h0000_4000; #1;
    chk("match_sel0", 32'(um_sel), 32'd0);
    um_addr = 32'h0001_0000; #1;
    chk("match_miss", 32'(um_hit), 32'd0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_ready",  32'(bus_a.m_ready), 32'd0);
    chk("rst_m_rdata",  bus_a.m_rdata,      32'h0);
    chk("rst_s_valid",  32'(bus_a.s_valid), 32'h0);
    chk("rst_s_addr",   bus_a.s_addr,       32'h0);
    chk("rst_err_flag", 32'(err_flag_a),    32'd0);
    chk("rst_err_addr", err_addr_a,         32'h0);
    reset = 1'b0;

    // Zero-wait read from slave1.
    txn_a(32'h0100_0010, 32'h0, 4'b0000, 0, lat, sv_hi, sv_seen, rdata, n_rdy, hold_ok);
    chk("rd_lat",     32'(lat),     32'd2);
    chk("rd_sv_len",  32'(sv_hi),   32'd1);
    chk("rd_sv_one",  32'(sv_seen), 32'b0010);
    chk("rd_rdata",   rdata,        32'h1234_5678);
    chk("rd_nrdy",    32'(n_rdy),   32'd1);
    chk("rd_errflag", 32'(err_flag_a), 32'd0);

    // Write to slave2 with five wait cycles.
    txn_a(32'h0200_0008, 32'h41, 4'b0001, 5, lat, sv_hi, sv_seen, rdata, n_rdy, hold_ok);
    chk("wr_sv_len", 32'(sv_hi),   32'd6);
    chk("wr_sv_one", 32'(sv_seen), 32'b0100);
    chk("wr_hold",   32'(hold_ok), 32'd1);
    chk("wr_lat",    32'(lat),     32'd7);
    chk("wr_nrdy",   32'(n_rdy),   32'd1);

    // Unmapped accesses: first error address is kept.
    txn_a(32'h0500_0000, 32'h0, 4'b0000, 1000, lat, sv_hi, sv_seen, rdata, n_rdy, hold_ok);
    chk("um_sv",      32'(sv_hi),   32'd0);
    chk("um_lat",     32'(lat),     32'd2);
    chk("um_rdata",   rdata,        32'hDEAD_BEEF);
    chk("um_errflag", 32'(err_flag_a), 32'd1);
    chk("um_erraddr", err_addr_a,   32'h0500_0000);
    txn_a(32'h0600_0000, 32'h0, 4'b0000, 1000, lat, sv_hi, sv_seen, rdata, n_rdy, hold_ok);
    chk("um2_erraddr", err_addr_a,  32'h0500_0000);
    chk("um2_nrdy",    32'(n_rdy),  32'd1);

    @(negedge clk); err_clear_a = 1'b1;
    @(posedge clk); #1;
    chk("clr_errflag", 32'(err_flag_a), 32'd0);
    @(negedge clk); err_clear_a = 1'b0;

    // Slave3 never ready: eight cycles of s_valid then timeout error.
    txn_a(32'h0300_0000, 32'h0, 4'b0000, 1000, lat, sv_hi, sv_seen, rdata, n_rdy, hold_ok);
    chk("to_sv_len",  32'(sv_hi),   32'd8);
    chk("to_sv_one",  32'(sv_seen), 32'b1000);
    chk("to_lat",     32'(lat),     32'd10);
    chk("to_rdata",   rdata,        32'hDEAD_BEEF);
    chk("to_errflag", 32'(err_flag_a), 32'd1);
    chk("to_erraddr", err_addr_a,   32'h0300_0000);
    chk("to_nrdy",    32'(n_rdy),   32'd1);

    @(negedge clk); err_clear_a = 1'b1;
    @(negedge clk); err_clear_a = 1'b0;

    // Ready arrives in the eighth cycle: ready beats the timeout.
    txn_a(32'h0300_0004, 32'h0, 4'b0000, 7, lat, sv_hi, sv_seen, rdata, n_rdy, hold_ok);
    chk("to8_sv_len",  32'(sv_hi),  32'd8);
    chk("to8_lat",     32'(lat),    32'd9);
    chk("to8_rdata",   rdata,       32'hCAFE_0003);
    chk("to8_errflag", 32'(err_flag_a), 32'd0);

    // Overlapping windows on DUT B: slave0 has priority.
    @(negedge clk);
    bus_b.m_valid = 1'b1;
    bus_b.m_addr  = 32'h0100_0000;
    bus_b.s_ready = 2'b11;
    @(posedge clk); #1;
    chk("ovl_sv", 32'(bus_b.s_valid), 32'b01);
    @(posedge clk); #1;
    chk("ovl_rdy",   32'(bus_b.m_ready), 32'd1);
    chk("ovl_rdata", bus_b.m_rdata,      32'hAAAA_0000);
    bus_b.m_valid = 1'b0;
    bus_b.s_ready = 2'b00;

    // Reset in the middle of an ACTIVE transaction on DUT A.
    @(negedge clk);
    bus_a.m_valid = 1'b1;
    bus_a.m_addr  = 32'h0100_0000;
    bus_a.m_wstrb = 4'b0000;
    bus_a.s_ready = '0;
    @(posedge clk); #1;
    chk("mr_sv_pre", 32'(bus_a.s_valid), 32'b0010);
    @(posedge clk); #1;
    bus_a.m_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mr_sv_drop", 32'(bus_a.s_valid), 32'b0000);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus_a.m_ready) cnt++;
    end
    chk("mr_no_rdy", 32'(cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/picobus_decoder.md
Name: picobus_decoder

Overview:
- Parametrised memory-bus fabric for the PicoRV32 native interface (valid/ready, addr, wdata, wstrb, rdata).
- Generalises the SoC's hard-wired address decode to NSLAVES channels, each with its own base/mask window.
- Adds a registered response path, a per-transaction ready timeout, and a sticky bus-error status for unmapped or hung accesses.
- Sits between the cpu instance and all RAM/firmware/peripheral/iomem slaves in the SoC top.

Parameters:
- NSLAVES, 4, number of slave channels (1..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width (multiple of 8); strobe width is DATA_W/8.
- SLAVE_BASE, {NSLAVES{32'h0}}, packed NSLAVES*ADDR_W base addresses; slave i occupies bits [i*ADDR_W +: ADDR_W].
- SLAVE_MASK, {NSLAVES{32'hFF00_0000}}, packed compare masks; slave i hits when (addr & mask_i) == (base_i & mask_i).
- TIMEOUT, 255, cycles to wait for s_ready before aborting; 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on an error response.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- m_valid  in  1  master request; held until m_ready.
- m_addr  in  ADDR_W  master address.
- m_wdata  in  DATA_W  master write data.
- m_wstrb  in  DATA_W/8  byte strobes; all-zero means read.
- m_rdata  out  DATA_W  registered read data.
- m_ready  out  1  single-cycle completion pulse.
- s_valid  out  NSLAVES  one-hot per-slave request.
- s_addr  out  ADDR_W  broadcast address, registered at decode.
- s_wdata  out  DATA_W  broadcast write data, registered at decode.
- s_wstrb  out  DATA_W/8  broadcast strobes, registered at decode.
- s_rdata  in  NSLAVES*DATA_W  packed slave read data.
- s_ready  in  NSLAVES  per-slave ready.
- err_clear  in  1  clears err_flag.
- err_flag  out  1  sticky bus-error indicator.
- err_addr  out  ADDR_W  address of the first error since last clear.

Behaviour:
- Reset values: m_ready=0, m_rdata=0, s_valid=0, s_addr/s_wdata/s_wstrb=0, err_flag=0, err_addr=0; state=IDLE; timeout counter=0.
- IDLE: when m_valid=1, latch m_addr/m_wdata/m_wstrb onto the s_* outputs and run the address decode.
  - Decode is priority-based: lowest-index matching slave wins.
  - Hit on slave i -> go to ACTIVE with s_valid[i]=1 from the next cycle.
  - No hit -> go to ERROR.
- ACTIVE:
  - s_valid[sel] stays high; the counter increments each cycle.
  - s_ready[sel]=1 -> capture s_rdata[sel] into m_rdata, drop s_valid, go to DONE.
  - s_ready on any other slave index is ignored.
  - TIMEOUT!=0 and counter==TIMEOUT-1 without ready -> drop s_valid, go to ERROR.
  - Ready and timeout in the same cycle: ready wins, no error.
- ERROR: one cycle. Load m_rdata=ERR_DATA, set err_flag, and load err_addr only if err_flag was 0 (first error is kept). Go to DONE.
- DONE: m_ready=1 for exactly one cycle, m_rdata valid; go to IDLE.
  - IDLE ignores m_valid in the cycle right after DONE. This gives one guard cycle for the master to drop valid.
- Latency: a zero-wait slave gives m_ready 3 cycles after m_valid is sampled (decode, slave cycle, DONE). An unmapped access gives m_ready after 3 cycles (decode, ERROR, DONE).
- Writes and reads follow the same flow; m_rdata on a write is don't-care but is still loaded from the slave.
- err_clear=1 clears err_flag the next cycle.
  - If it coincides with a new error, set wins and err_addr takes the new address.
- Counter width is clog2(TIMEOUT+1); it resets to 0 on every entry to ACTIVE.
- Reset asserted mid-transaction: return to IDLE next edge and drop s_valid immediately. No m_ready is produced for the aborted access.
- Overlapping windows are legal and resolved by priority. NSLAVES=1 has no special case.

Decomposition:
- picobus_pkg:
  - state encoding IDLE/ACTIVE/ERROR/DONE (2-bit);
  - default ERR_DATA constant;
  - clog2 helper function.
- Sub-module picobus_addr_match: combinational, parametrised on NSLAVES/ADDR_W/SLAVE_BASE/SLAVE_MASK.
  - Outputs hit and the binary index sel.
  - Unit-tested on its own.
- FSM, timeout counter, response register and error status stay in picobus_decoder.

Test Plan:
- NSLAVES=4, bases 0x0000_0000/0x0100_0000/0x0200_0000/0x0300_0000, mask 0xFF00_0000. Read 0x0100_0010 with slave1 ready on first cycle, rdata 0x1234_5678 -> s_valid=4'b0010 for 1 cycle, m_ready 3 cycles after m_valid, m_rdata=0x1234_5678, err_flag=0.
- Write 0x0200_0008, wstrb 4'b0001, wdata 0x41; slave2 ready after 5 wait cycles -> s_wstrb=4'b0001 and s_wdata=0x41 held throughout, m_ready exactly once.
- Access 0x0500_0000 (unmapped) -> no s_valid, m_rdata=0xDEAD_BEEF, err_flag=1, err_addr=0x0500_0000. A second unmapped access to 0x0600_0000 leaves err_addr unchanged. err_clear then drops err_flag.
- TIMEOUT=8, slave3 never ready -> s_valid[3] high for 8 cycles then low, m_ready with 0xDEAD_BEEF, err_flag=1. Repeat with s_ready in the 8th cycle -> normal data, no error.
- Overlap: slave0 base 0x0 mask 0x0 (matches all) plus slave1 -> 0x0100_0000 routes to slave0. Reset pulsed during ACTIVE -> s_valid=0 the next cycle and no m_ready.
